// File: rtl/td4_pkg.sv
// Shared constants for the TD4 program store and its in-system loader.
package td4_pkg;
    localparam int TD4_ADDR_W = 4;
    localparam int TD4_DATA_W = 8;
    localparam int PROG_DEPTH = 16;

    // Loader FSM encoding, kept as plain constants so older tools can read it.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_OK    = 3'd3;
    localparam logic [2:0] ST_FAIL  = 3'd4;
endpackage

// File: rtl/td4_prog_ram.sv
// Program storage: synchronous write, synchronous clear, combinational A->D fetch.
module td4_prog_ram
    import td4_pkg::*;
#(
    parameter int ADDR_W = TD4_ADDR_W,
    parameter int DATA_W = TD4_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Unregistered so the core fetches exactly as from the fixed ROM.
    assign D = mem[A];
endmodule

// File: rtl/td4_program_loader.sv
// Writable TD4 program store filled from a byte stream; holds the CPU while loading.
module td4_program_loader
    import td4_pkg::*;
#(
    parameter int ADDR_W   = TD4_ADDR_W,
    parameter int DATA_W   = TD4_DATA_W,
    parameter int CHECK_EN = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              IN_READY,
    output logic              CPU_HOLD,
    output logic              DONE,
    output logic              ERR,
    input  logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    output logic [2:0]        dbg_state
);
    // Handshake: a byte moves on every rising edge where IN_VALID && IN_READY;
    // IN_READY depends only on state, never on IN_VALID, and the sender may
    // hold IN_VALID low for any number of cycles.
    logic [2:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_next;
    logic              xfer;

    assign xfer     = IN_VALID & IN_READY;
    assign sum_next = sum + IN_DATA;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            ptr   <= '0;
            sum   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_OK, ST_FAIL: begin
                    if (START) begin
                        state <= ST_LOAD;
                        ptr   <= '0;
                        sum   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        ptr <= ptr + 1'b1;
                        sum <= sum_next;
                        if (&ptr) begin
                            state <= (CHECK_EN != 0) ? ST_CHECK : ST_OK;
                        end
                    end
                end
                ST_CHECK: begin
                    // Checksum byte makes the whole stream sum to zero; it is not stored.
                    if (xfer) begin
                        state <= (sum_next == '0) ? ST_OK : ST_FAIL;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign IN_READY  = (state == ST_LOAD) || (state == ST_CHECK);
    assign CPU_HOLD  = (state == ST_LOAD) || (state == ST_CHECK) || (state == ST_FAIL);
    assign DONE      = (state == ST_OK);
    assign ERR       = (state == ST_FAIL);
    assign dbg_state = state;

    td4_prog_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .CLK  (CLK),
        .RST  (RST),
        .we   ((state == ST_LOAD) && xfer),
        .waddr(ptr),
        .wdata(IN_DATA),
        .A    (A),
        .D    (D)
    );
endmodule

// File: tb/tb_td4_program_loader.sv
// Self-checking bench for td4_program_loader against a byte-stream reference model.
module tb_td4_program_loader;
    import td4_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic       IN_VALID;
    logic [7:0] IN_DATA;
    logic       IN_READY;
    logic       CPU_HOLD;
    logic       DONE;
    logic       ERR;
    logic [3:0] A;
    logic [7:0] D;
    logic [2:0] dbg_state;

    td4_program_loader dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .IN_VALID (IN_VALID),
        .IN_DATA  (IN_DATA),
        .IN_READY (IN_READY),
        .CPU_HOLD (CPU_HOLD),
        .DONE     (DONE),
        .ERR      (ERR),
        .A        (A),
        .D        (D),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    // Reference model: program image, bytes of the current load, load status.
    logic [7:0] model_mem [16];
    logic [7:0] exp_q [$];
    bit         m_busy     = 0;
    bit         m_done     = 0;
    bit         m_err      = 0;
    bit         mem_known  = 0;
    logic [7:0] img [16];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: check D before the edge, advance the model, check all outputs after.
    task automatic step();
        int s;
        #1;
        if (mem_known) check_eq("d_pre_edge", D, model_mem[A]);
        if (RST) begin
            for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
            exp_q.delete();
            m_busy    = 0;
            m_done    = 0;
            m_err     = 0;
            mem_known = 1;
        end else if (m_busy) begin
            if (IN_VALID) begin
                exp_q.push_back(IN_DATA);
                if (exp_q.size() <= 16) model_mem[exp_q.size() - 1] = IN_DATA;
                if (exp_q.size() == 17) begin
                    s = 0;
                    foreach (exp_q[i]) s += int'(exp_q[i]);
                    m_busy = 0;
                    m_done = ((s % 256) == 0);
                    m_err  = !m_done;
                end
            end
        end else if (START) begin
            m_busy = 1;
            m_done = 0;
            m_err  = 0;
            exp_q.delete();
        end
        @(posedge CLK);
        #1;
        cyc++;
        check_eq("in_ready", IN_READY, m_busy);
        check_eq("cpu_hold", CPU_HOLD, m_busy | m_err);
        check_eq("done", DONE, m_done);
        check_eq("err", ERR, m_err);
        if (mem_known) check_eq("d_post_edge", D, model_mem[A]);
    endtask

    // driver tasks
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            START    = 0;
            IN_VALID = 0;
            A        = 4'($urandom_range(0, 15));
            step();
        end
    endtask

    task automatic do_start();
        START    = 1;
        IN_VALID = 0;
        A        = 4'($urandom_range(0, 15));
        step();
        START = 0;
    endtask

    task automatic send(input logic [7:0] data, input int gap, input bit poke);
        for (int i = 0; i < gap; i++) begin
            IN_VALID = 0;
            IN_DATA  = 8'($urandom);
            START    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            A        = 4'($urandom_range(0, 15));
            step();
        end
        START    = 0;
        IN_VALID = 1;
        IN_DATA  = data;
        A        = 4'($urandom_range(0, 15));
        check_eq("ready_at_send", IN_READY, 1);
        step();
        IN_VALID = 0;
    endtask

    task automatic load(input logic [7:0] chk, input int max_gap, input bit poke);
        do_start();
        for (int i = 0; i < 16; i++) send(img[i], $urandom_range(0, max_gap), poke);
        send(chk, $urandom_range(0, max_gap), poke);
    endtask

    task automatic check_image();
        for (int i = 0; i < 16; i++) begin
            START    = 0;
            IN_VALID = 0;
            A        = 4'(i);
            step();
        end
    endtask

    function automatic logic [7:0] good_chk();
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(img[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    initial begin
        int c0;
        RST = 1; START = 1; IN_VALID = 0; IN_DATA = 8'h00; A = 4'h0;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

        // Reset together with START: reset wins.
        step();
        RST = 0; START = 0;
        check_eq("rst_state", dbg_state, ST_IDLE);
        for (int i = 0; i < 16; i++) begin
            A = 4'(i);
            step();
            check_eq("rst_image", D, 8'h00);
        end

        // Good load, back-to-back; START arrives alongside IN_VALID in IDLE.
        for (int i = 0; i < 16; i++) img[i] = 8'(i + 1);
        c0 = cyc;
        START = 1; IN_VALID = 1; IN_DATA = 8'hEE; A = 4'h0;
        step();
        START = 0; IN_VALID = 0;
        for (int i = 0; i < 16; i++) send(img[i], 0, 0);
        send(8'h78, 0, 0);
        check_eq("good_cycles", cyc - c0, 18);
        check_eq("good_done", DONE, 1);
        check_eq("good_hold", CPU_HOLD, 0);
        A = 4'h5;
        step();
        check_eq("good_d5", D, 8'h06);

        // Bad checksum keeps the image and the hold.
        load(8'h77, 0, 0);
        check_eq("bad_err", ERR, 1);
        check_eq("bad_done", DONE, 0);
        check_eq("bad_hold", CPU_HOLD, 1);
        for (int i = 0; i < 16; i++) begin
            A = 4'(i);
            step();
            check_eq("bad_image", D, 8'(i + 1));
        end
        load(8'h78, 0, 0);
        check_eq("recover_done", DONE, 1);

        // Random images with IN_VALID stalls and stray START pulses.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
            load((k % 3 == 2) ? 8'($urandom) : good_chk(), 5, 1);
            check_image();
            idle($urandom_range(0, 3));
        end
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
        load(good_chk(), 5, 1);
        check_eq("stall_done", DONE, 1);

        // Reset after 7 bytes.
        do_start();
        for (int i = 0; i < 7; i++) send(8'($urandom), $urandom_range(0, 2), 0);
        RST = 1;
        step();
        RST = 0;
        check_eq("midrst_state", dbg_state, ST_IDLE);
        check_eq("midrst_hold", CPU_HOLD, 0);
        for (int i = 0; i < 16; i++) begin
            A = 4'(i);
            step();
            check_eq("midrst_image", D, 8'h00);
        end

        // Write visibility at address 3.
        do_start();
        for (int i = 0; i < 3; i++) send(8'(i + 16), 0, 0);
        A = 4'h3; IN_VALID = 1; IN_DATA = 8'hA5;
        #1;
        check_eq("vis_pre", D, 8'h00);
        step();
        IN_VALID = 0;
        check_eq("vis_post", D, 8'hA5);
        for (int i = 4; i < 16; i++) send(8'($urandom), $urandom_range(0, 2), 0);
        send(8'($urandom), 0, 0);
        check_image();

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
